// File: rtl/memcpy_sched_pkg.sv
// Shared types and constants for the memcpy scheduler: FSM encoding, statistics
// width, requester limit and a saturating increment used by the statistics counters.
package memcpy_sched_pkg;

  localparam int STAT_WIDTH  = 32;
  localparam int MAX_NUM_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    sat_inc = (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant_i and
// wraps modulo N; the first requesting index wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  int   cand;
  logic found;
  logic hit;

  // Priority rotate without branches: each candidate can only win while nothing earlier has.
  always_comb begin
    gnt_o     = {N{1'b0}};
    gnt_idx_o = {IW{1'b0}};
    found     = 1'b0;
    cand      = 0;
    hit       = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand        = (int'(last_grant_i) + k) % N;
      hit         = en_i && !found && req_i[cand];
      gnt_o[cand] = gnt_o[cand] | hit;
      gnt_idx_o   = hit ? cand[IW-1:0] : gnt_idx_o;
      found       = found | hit;
    end
  end

endmodule

// File: rtl/memcpy_scheduler.sv
// Shares one memcpy_engine among NUM_REQ requesters with round-robin arbitration.
// Optional per-requester job and busy-cycle counters are built when MEMCPY_SCHED_STATS_EN is defined.
module memcpy_scheduler
  import memcpy_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_src_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_tgt_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]     req_len,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [ADDR_WIDTH-1:0]            memcpy_src_addr,
  output logic [ADDR_WIDTH-1:0]            memcpy_tgt_addr,
  output logic [LEN_WIDTH-1:0]             memcpy_len,
  output logic                             memcpy_start,
  input  logic                             memcpy_done,
  output logic                             sched_busy,
  output logic [$clog2(NUM_REQ)-1:0]       sched_owner,
  output logic [NUM_REQ*STAT_WIDTH-1:0]    stat_jobs,
  output logic [STAT_WIDTH-1:0]            stat_busy_cycles
);

  localparam int OWN_W = $clog2(NUM_REQ);

  sched_state_e          state_q, state_d;
  logic [OWN_W-1:0]      owner_q, owner_d;
  logic [OWN_W-1:0]      last_q, last_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [NUM_REQ-1:0]    rdone_q, rdone_d;
  logic                  done_q;
  logic                  start_q;
  logic                  busy_q;

  logic [NUM_REQ-1:0]    gnt_s;
  logic [OWN_W-1:0]      gnt_idx_s;
  logic                  arb_en_s;
  logic                  done_rise_s;

  // Arbitration only in IDLE; reset suppresses the accept pulse as well.
  assign arb_en_s    = (state_q == ST_IDLE) && !rst;
  assign done_rise_s = memcpy_done & ~done_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .en_i         (arb_en_s),
    .gnt_o        (gnt_s),
    .gnt_idx_o    (gnt_idx_s)
  );

  // Next-state logic; the descriptor is latched only on a grant so the engine inputs stay stable.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    src_d   = src_q;
    tgt_d   = tgt_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt_s) begin
          owner_d = gnt_idx_s;
          last_d  = gnt_idx_s;
          src_d   = req_src_addr[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
          tgt_d   = req_tgt_addr[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
          len_d   = req_len[int'(gnt_idx_s)*LEN_WIDTH +: LEN_WIDTH];
          state_d = (len_d == {LEN_WIDTH{1'b0}}) ? ST_DONE : ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: state_d = ST_WAIT;
      // A done level carried over from the previous job is not an edge and is ignored.
      ST_WAIT:  state_d = done_rise_s ? ST_DONE : ST_WAIT;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    rdone_d          = {NUM_REQ{1'b0}};
    rdone_d[owner_d] = (state_d == ST_DONE);
  end

  // State, descriptor and pulse registers; pulses are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= {OWN_W{1'b0}};
      last_q  <= OWN_W'(NUM_REQ - 1);
      src_q   <= {ADDR_WIDTH{1'b0}};
      tgt_q   <= {ADDR_WIDTH{1'b0}};
      len_q   <= {LEN_WIDTH{1'b0}};
      rdone_q <= {NUM_REQ{1'b0}};
      done_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      src_q   <= src_d;
      tgt_q   <= tgt_d;
      len_q   <= len_d;
      rdone_q <= rdone_d;
      done_q  <= memcpy_done;
      start_q <= (state_d == ST_START);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign req_ready       = gnt_s;
  assign req_done        = rdone_q;
  assign memcpy_src_addr = src_q;
  assign memcpy_tgt_addr = tgt_q;
  assign memcpy_len      = len_q;
  assign memcpy_start    = start_q;
  assign sched_busy      = busy_q;
  assign sched_owner     = owner_q;

`ifdef MEMCPY_SCHED_STATS_EN
  logic [STAT_WIDTH-1:0] jobs_q [NUM_REQ];
  logic [STAT_WIDTH-1:0] busy_cnt_q;

  // Saturating statistics, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        jobs_q[i] <= {STAT_WIDTH{1'b0}};
      end
      busy_cnt_q <= {STAT_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        jobs_q[i] <= rdone_q[i] ? sat_inc(jobs_q[i]) : jobs_q[i];
      end
      busy_cnt_q <= busy_q ? sat_inc(busy_cnt_q) : busy_cnt_q;
    end
  end

  // Pack the per-requester counters onto the flat statistics port.
  always_comb begin
    stat_jobs = {(NUM_REQ*STAT_WIDTH){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_jobs[i*STAT_WIDTH +: STAT_WIDTH] = jobs_q[i];
    end
  end

  assign stat_busy_cycles = busy_cnt_q;
`else
  assign stat_jobs        = {(NUM_REQ*STAT_WIDTH){1'b0}};
  assign stat_busy_cycles = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_memcpy_scheduler.sv
// Self-checking bench for memcpy_scheduler: requester/engine models plus a job scoreboard,
// a vector table of single jobs and hand-written round-robin, held-done, reset and stats sequences.
module tb_memcpy_scheduler;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int LW = 64;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_src_addr;
  logic [N*AW-1:0]   req_tgt_addr;
  logic [N*LW-1:0]   req_len;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_done;
  logic [AW-1:0]     memcpy_src_addr;
  logic [AW-1:0]     memcpy_tgt_addr;
  logic [LW-1:0]     memcpy_len;
  logic              memcpy_start;
  logic              memcpy_done;
  logic              sched_busy;
  logic [1:0]        sched_owner;
  logic [N*32-1:0]   stat_jobs;
  logic [31:0]       stat_busy_cycles;

  memcpy_scheduler #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_src_addr     (req_src_addr),
    .req_tgt_addr     (req_tgt_addr),
    .req_len          (req_len),
    .req_ready        (req_ready),
    .req_done         (req_done),
    .memcpy_src_addr  (memcpy_src_addr),
    .memcpy_tgt_addr  (memcpy_tgt_addr),
    .memcpy_len       (memcpy_len),
    .memcpy_start     (memcpy_start),
    .memcpy_done      (memcpy_done),
    .sched_busy       (sched_busy),
    .sched_owner      (sched_owner),
    .stat_jobs        (stat_jobs),
    .stat_busy_cycles (stat_busy_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [63:0] src;
    logic [63:0] tgt;
    logic [63:0] len;
    int          lat;
    int          t_ready;
  } job_t;

  typedef struct {
    int          idx;
    logic [63:0] src;
    logic [63:0] tgt;
    logic [63:0] len;
    int          lat;
    int          exp_owner;
    int          exp_starts;
    int          exp_lat;
  } vec_t;

  job_t pend_q[$];
  job_t exp_q[$];
  int   exp_order[$];
  vec_t vecs[5];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int done_total = 0;
  int n_starts = 0;
  int cur_lat = 1;
  int eng_drop = 0;
  int eng_cnt = 0;
  bit hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_job(input int idx, input logic [63:0] src, input logic [63:0] tgt,
                         input logic [63:0] len, input int lat);
    job_t j;
    j.idx = idx; j.src = src; j.tgt = tgt; j.len = len; j.lat = lat; j.t_ready = 0;
    pend_q.push_back(j);
  endtask

  // Each requester presents its oldest pending descriptor.
  task automatic drive_reqs();
    bit hit;
    for (int i = 0; i < N; i++) begin
      hit = 1'b0;
      req_valid[i] = 1'b0;
      for (int k = 0; k < pend_q.size(); k++) begin
        if (!hit && pend_q[k].idx == i) begin
          hit = 1'b1;
          req_valid[i] = 1'b1;
          req_src_addr[i*AW +: AW] = pend_q[k].src;
          req_tgt_addr[i*AW +: AW] = pend_q[k].tgt;
          req_len[i*LW +: LW]      = pend_q[k].len;
        end
      end
    end
  endtask

  task automatic monitor();
    job_t j;
    int   gi;
    bit   found;
    if (rst) begin
      exp_q.delete();
      return;
    end
    if (req_ready != '0) begin
      check("ready_onehot", $onehot(req_ready), 1);
      check("ready_while_busy", sched_busy, 0);
      gi = 0;
      for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
      if (exp_order.size() > 0) check("grant_order", gi, exp_order.pop_front());
      found = 1'b0;
      for (int k = 0; k < pend_q.size(); k++) begin
        if (!found && pend_q[k].idx == gi) begin
          found = 1'b1;
          j = pend_q[k];
          j.t_ready = cyc;
          exp_q.push_back(j);
          pend_q.delete(k);
          cur_lat = j.lat;
          eng_drop = j.lat / 2;
        end
      end
      check("ready_has_req", found, 1);
    end
    if (memcpy_start) begin
      if (exp_q.size() == 0) begin
        check("start_unexpected", memcpy_start, 0);
      end else begin
        j = exp_q[0];
        n_starts++;
        check("start_delay", cyc - j.t_ready, 1);
        check("start_src", memcpy_src_addr, j.src);
        check("start_tgt", memcpy_tgt_addr, j.tgt);
        check("start_len", memcpy_len, j.len);
      end
    end
    if (req_done != '0) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", req_done, 0);
      end else begin
        j = exp_q.pop_front();
        done_total++;
        check("done_idx", req_done, 64'd1 << j.idx);
        check("done_lat", cyc - j.t_ready, (j.len == 64'd0) ? 1 : j.lat + 2);
        check("done_owner", sched_owner, j.idx);
        check("done_busy", sched_busy, 1);
      end
    end
  endtask

  // Engine model: done rises lat cycles after start; in hold mode it stays high and
  // only drops midway through the next job.
  task automatic engine_step();
    if (rst) begin
      eng_cnt = 0;
      memcpy_done = 1'b0;
    end else if (memcpy_start) begin
      eng_cnt = cur_lat;
      if (!hold) memcpy_done = 1'b0;
    end else if (eng_cnt != 0) begin
      if (eng_cnt == 1) memcpy_done = 1'b1;
      else if (hold && eng_cnt == eng_drop) memcpy_done = 1'b0;
      else if (!hold) memcpy_done = 1'b0;
      eng_cnt--;
    end else if (!hold) begin
      memcpy_done = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      drive_reqs();
      @(negedge clk);
      monitor();
      engine_step();
    end
  end

  task automatic wait_jobs(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_total < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, done_total, target);
  endtask

  task automatic check_reset(input string p);
    check({p, "_ready"}, req_ready, 0);
    check({p, "_done"}, req_done, 0);
    check({p, "_start"}, memcpy_start, 0);
    check({p, "_src"}, memcpy_src_addr, 0);
    check({p, "_tgt"}, memcpy_tgt_addr, 0);
    check({p, "_len"}, memcpy_len, 0);
    check({p, "_busy"}, sched_busy, 0);
    check({p, "_owner"}, sched_owner, 0);
    check({p, "_stat_jobs"}, stat_jobs != '0, 0);
    check({p, "_stat_busy"}, stat_busy_cycles, 0);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int s0;
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_src_addr = '0;
    req_tgt_addr = '0;
    req_len = '0;
    memcpy_done = 1'b0;

    vecs[0] = '{2, 64'h1000, 64'h8000, 64'h400, 20, 2, 1, 22};
    vecs[1] = '{1, 64'h2000, 64'h3000, 64'h0, 5, 1, 0, 1};
    vecs[2] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1, 1, 0, 1, 3};
    vecs[3] = '{3, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'hFFFF_FFFF_FFFF_FFFF, 5, 3, 1, 7};
    vecs[4] = '{3, 64'h40, 64'h80, 64'h10, 2, 3, 1, 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1 rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      s0 = n_starts;
      d0 = done_total;
      add_job(vecs[v].idx, vecs[v].src, vecs[v].tgt, vecs[v].len, vecs[v].lat);
      wait_jobs(d0 + 1, 200, $sformatf("vec%0d_wait", v));
      @(negedge clk);
      check($sformatf("vec%0d_owner", v), sched_owner, vecs[v].exp_owner);
      check($sformatf("vec%0d_starts", v), n_starts - s0, vecs[v].exp_starts);
      check($sformatf("vec%0d_idle", v), sched_busy, 0);
      repeat (2) @(posedge clk);
    end

    // All four requesters valid continuously for two rounds.
    pulse_rst();
    exp_order = {0, 1, 2, 3, 0, 1, 2, 3};
    d0 = done_total;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        add_job(i, 64'h1_0000 * (i + 1) + 64'(r), 64'h9_0000 + 64'h100 * i, 64'h40 + 64'(r), 3);
    wait_jobs(d0 + 8, 400, "rr_wait");
    check("rr_order_left", exp_order.size(), 0);

    // Engine keeps done high after each completion.
    hold = 1'b1;
    d0 = done_total;
    add_job(0, 64'hA000, 64'hB000, 64'h20, 8);
    wait_jobs(d0 + 1, 100, "hold_a_wait");
    repeat (3) @(posedge clk);
    add_job(1, 64'hC000, 64'hD000, 64'h30, 8);
    wait_jobs(d0 + 2, 100, "hold_b_wait");
    repeat (12) @(posedge clk);
    check("hold_once", done_total, d0 + 2);
    hold = 1'b0;
    repeat (3) @(posedge clk);

    // Reset while waiting on the engine.
    d0 = done_total;
    s0 = n_starts;
    add_job(2, 64'hE000, 64'hF000, 64'h80, 30);
    n = 0;
    while (n_starts == s0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("rst_job_started", n_starts, s0 + 1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset("wait_rst");
    repeat (40) @(posedge clk);
    check("rst_no_done", done_total, d0);
    exp_order = {0};
    for (int i = 0; i < N; i++) add_job(i, 64'h5000 + 64'(i), 64'h6000 + 64'(i), 64'h8, 2);
    wait_jobs(d0 + 4, 300, "rst_rr_wait");
    check("rst_order_left", exp_order.size(), 0);

    // Statistics: three jobs on requester 3 with 10/20/30 engine cycles.
    pulse_rst();
    d0 = done_total;
    add_job(3, 64'h100, 64'h200, 64'h10, 10);
    add_job(3, 64'h300, 64'h400, 64'h20, 20);
    add_job(3, 64'h500, 64'h600, 64'h30, 30);
    wait_jobs(d0 + 3, 400, "stats_wait");
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef MEMCPY_SCHED_STATS_EN
    check("stat_jobs3", stat_jobs[3*32 +: 32], 3);
    check("stat_jobs0", stat_jobs[0 +: 32], 0);
    check("stat_busy", stat_busy_cycles, 66);
`else
    check("stat_jobs3", stat_jobs[3*32 +: 32], 0);
    check("stat_jobs0", stat_jobs[0 +: 32], 0);
    check("stat_busy", stat_busy_cycles, 0);
`endif

    check("sb_empty", exp_q.size(), 0);
    check("pend_empty", pend_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
